// File: rtl/pdm_sample_sequencer.sv
// pdm_sample_sequencer
// Buffers upstream 8-bit samples in a small FIFO and feeds them to a
// first-order PDM modulator core, one registered write strobe per sample
// period. Stopping drains the FIFO at the sample rate and finishes with a
// single write of the mute code before going idle.
module pdm_sample_sequencer #(
    parameter int                     BITWIDTH   = 8,
    parameter int                     FIFO_DEPTH = 4,
    parameter int                     PERIOD_W   = 16,
    parameter logic [BITWIDTH-1:0]    IDLE_CODE  = {BITWIDTH{1'b0}}
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [PERIOD_W-1:0]           period,
    input  logic [BITWIDTH-1:0]           s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [BITWIDTH-1:0]           pdm_input,
    output logic                          write_en,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [PERIOD_W-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]         rdPtr_q, wrPtr_q;
    logic [LW-1:0]         level_q;
    logic [BITWIDTH-1:0]   mem [FIFO_DEPTH];
    logic [BITWIDTH-1:0]   pdmInput_q, pdmInput_d;
    logic                  writeEn_q, writeEn_d;
    logic                  underflow_q, underflow_d;
    logic                  enablePrev_q;

    logic                  fifoFull;
    logic                  fifoEmpty;
    logic                  push;
    logic                  pop;
    logic                  tick;

    // Full/empty come straight from the registered level, so s_ready never
    // depends on a pop happening in the same cycle.
    assign fifoFull  = (level_q == LW'(FIFO_DEPTH));
    assign fifoEmpty = (level_q == '0);
    assign push      = s_valid && !fifoFull;
    assign tick      = (state_q != IDLE) && (cnt_q >= period);

    assign s_ready    = !fifoFull;
    assign pdm_input  = pdmInput_q;
    assign write_en   = writeEn_q;
    assign busy       = (state_q != IDLE);
    assign fifo_level = level_q;
    assign underflow  = underflow_q;

    // Rate divider: held at zero while idle, wraps to zero on every tick.
    always_comb begin
        cnt_d = cnt_q + PERIOD_W'(1);
        if (state_q == IDLE || tick) begin
            cnt_d = '0;
        end
    end

    // Next-state and output strobe logic; enable wins over the final drain
    // tick so a restart during DRAIN never emits the mute code.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        writeEn_d   = 1'b0;
        pdmInput_d  = pdmInput_q;
        underflow_d = underflow_q;

        if (enable && !enablePrev_q) begin
            underflow_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (tick) begin
                    if (!fifoEmpty) begin
                        pop        = 1'b1;
                        writeEn_d  = 1'b1;
                        pdmInput_d = mem[rdPtr_q];
                    end else begin
                        underflow_d = 1'b1;
                    end
                end
                if (!enable) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (tick && !fifoEmpty) begin
                    pop        = 1'b1;
                    writeEn_d  = 1'b1;
                    pdmInput_d = mem[rdPtr_q];
                end
                if (enable) begin
                    state_d = RUN;
                end else if (tick && fifoEmpty) begin
                    writeEn_d  = 1'b1;
                    pdmInput_d = IDLE_CODE;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state, divider, FIFO pointers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rdPtr_q      <= '0;
            wrPtr_q      <= '0;
            level_q      <= '0;
            pdmInput_q   <= '0;
            writeEn_q    <= 1'b0;
            underflow_q  <= 1'b0;
            enablePrev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pdmInput_q   <= pdmInput_d;
            writeEn_q    <= writeEn_d;
            underflow_q  <= underflow_d;
            enablePrev_q <= enable;
            if (push) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            if (push && !pop) begin
                level_q <= level_q + LW'(1);
            end else if (pop && !push) begin
                level_q <= level_q - LW'(1);
            end
        end
    end

    // Sample storage; contents need no reset because the pointers define
    // which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr_q] <= s_data;
        end
    end

endmodule

// File: tb/tb_pdm_sample_sequencer.sv
// Testbench for pdm_sample_sequencer: directed scenarios with randomized
// sample data plus randomized traffic compared against a queue-based model.
module tb_pdm_sample_sequencer;

    localparam int DEPTH = 4;
    localparam logic [7:0] MUTE = 8'h00;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] period = '0;
    logic [7:0]  sData = '0;
    logic        sValid = 1'b0;
    logic        sReady;
    logic [7:0]  pdmInput;
    logic        writeEn;
    logic        busy;
    logic [2:0]  fifoLevel;
    logic        underflow;

    int compared = 0;
    int mismatched = 0;

    // Reference model state: sample queue, mode (0 idle, 1 run, 2 drain),
    // cycles elapsed since the divider last restarted.
    logic [7:0] mq[$];
    int         mMode;
    int         mIdx;
    int         mPer;
    bit         mPrevEn;
    logic [7:0] mOut;
    bit         mWe;
    bit         mUf;

    pdm_sample_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .period     (period),
        .s_data     (sData),
        .s_valid    (sValid),
        .s_ready    (sReady),
        .pdm_input  (pdmInput),
        .write_en   (writeEn),
        .busy       (busy),
        .fifo_level (fifoLevel),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input int p);
        reset  = 1'b1;
        enable = 1'b0;
        sValid = 1'b0;
        sData  = '0;
        period = 16'(p);
        step();
        reset = 1'b0;
    endtask

    task automatic preload(input int n, output logic [7:0] s [4]);
        for (int k = 0; k < n; k++) begin
            s[k]   = 8'($urandom_range(1, 255));
            sValid = 1'b1;
            sData  = s[k];
            step();
        end
        sValid = 1'b0;
    endtask

    function automatic void modelReset(input int p);
        mq.delete();
        mMode   = 0;
        mIdx    = 0;
        mPer    = p;
        mPrevEn = 1'b0;
        mOut    = '0;
        mWe     = 1'b0;
        mUf     = 1'b0;
    endfunction

    // One clock of the behavioural model, applied with the inputs driven
    // during that clock; afterwards the m* fields hold the expected outputs.
    function automatic void modelStep(input bit v, input logic [7:0] d, input bit en);
        int sz = mq.size();
        bit doPush = v && (sz < DEPTH);
        bit tick;
        mWe = 1'b0;
        if (en && !mPrevEn) mUf = 1'b0;
        if (mMode == 0) begin
            if (en) begin
                mMode = 1;
                mIdx  = 0;
            end
        end else begin
            tick = ((mIdx % (mPer + 1)) == mPer);
            mIdx++;
            if (tick && sz > 0) begin
                mOut = mq.pop_front();
                mWe  = 1'b1;
            end
            if (mMode == 1) begin
                if (tick && sz == 0) mUf = 1'b1;
                if (!en) mMode = 2;
            end else begin
                if (en) begin
                    mMode = 1;
                end else if (tick && sz == 0) begin
                    mOut  = MUTE;
                    mWe   = 1'b1;
                    mMode = 0;
                end
            end
        end
        if (doPush) mq.push_back(d);
        mPrevEn = en;
    endfunction

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b1;
        sValid = 1'b1;
        sData  = 8'hA5;
        period = 16'd3;
        step();
        compared++; if (writeEn !== 1'b0)   begin mismatched++; $display("[TB] FAIL reset_write_en: got %b expected 0", writeEn); end
        compared++; if (pdmInput !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_pdm_input: got %h expected 00", pdmInput); end
        compared++; if (underflow !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_underflow: got %b expected 0", underflow); end
        compared++; if (sReady !== 1'b1)    begin mismatched++; $display("[TB] FAIL reset_s_ready: got %b expected 1", sReady); end
        compared++; if (busy !== 1'b0)      begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        compared++; if (fifoLevel !== 3'd0) begin mismatched++; $display("[TB] FAIL reset_fifo_level: got %0d expected 0", fifoLevel); end
        enable = 1'b0;
        sValid = 1'b0;
        reset  = 1'b0;
        step();
    endtask

    task automatic test_preload();
        logic [7:0] s [4];
        bit expWe;
        doReset(3);
        preload(3, s);
        compared++; if (fifoLevel !== 3'd3) begin mismatched++; $display("[TB] FAIL preload_level: got %0d expected 3", fifoLevel); end
        compared++; if (busy !== 1'b0)      begin mismatched++; $display("[TB] FAIL preload_idle_busy: got %b expected 0", busy); end
        enable = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            expWe = (c == 5 || c == 9 || c == 13);
            compared++; if (writeEn !== expWe) begin mismatched++; $display("[TB] FAIL preload_we c=%0d: got %b expected %b", c, writeEn, expWe); end
            if (expWe) begin
                compared++; if (pdmInput !== s[(c - 5) / 4]) begin mismatched++; $display("[TB] FAIL preload_data c=%0d: got %h expected %h", c, pdmInput, s[(c - 5) / 4]); end
            end
            compared++; if (underflow !== (c >= 17)) begin mismatched++; $display("[TB] FAIL preload_underflow c=%0d: got %b expected %b", c, underflow, (c >= 17)); end
        end
    endtask

    task automatic test_full_pop();
        logic [7:0] s [4];
        int expLvl [6] = '{4, 4, 3, 4, 3, 4};
        doReset(1);
        preload(4, s);
        compared++; if (sReady !== 1'b0) begin mismatched++; $display("[TB] FAIL full_s_ready: got %b expected 0", sReady); end
        sValid = 1'b1;
        sData  = 8'h5A;
        enable = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            compared++; if (fifoLevel !== 3'(expLvl[c - 1])) begin mismatched++; $display("[TB] FAIL full_level c=%0d: got %0d expected %0d", c, fifoLevel, expLvl[c - 1]); end
            compared++; if (sReady !== (expLvl[c - 1] != 4)) begin mismatched++; $display("[TB] FAIL full_ready c=%0d: got %b expected %b", c, sReady, (expLvl[c - 1] != 4)); end
        end
        sValid = 1'b0;
        enable = 1'b0;
    endtask

    task automatic test_drain();
        logic [7:0] s [4];
        logic [7:0] s2 [4];
        bit expWe;
        logic [7:0] expD;
        doReset(2);
        preload(2, s);
        enable = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            step();
            expWe = (c == 4 || c == 7 || c == 10);
            expD  = (c == 4) ? s[0] : (c == 7) ? s[1] : MUTE;
            compared++; if (writeEn !== expWe) begin mismatched++; $display("[TB] FAIL drain_we c=%0d: got %b expected %b", c, writeEn, expWe); end
            if (expWe) begin
                compared++; if (pdmInput !== expD) begin mismatched++; $display("[TB] FAIL drain_data c=%0d: got %h expected %h", c, pdmInput, expD); end
            end
            compared++; if (busy !== (c < 10)) begin mismatched++; $display("[TB] FAIL drain_busy c=%0d: got %b expected %b", c, busy, (c < 10)); end
            if (c == 1) enable = 1'b0;
        end
        compared++; if (underflow !== 1'b0) begin mismatched++; $display("[TB] FAIL drain_underflow: got %b expected 0", underflow); end
        preload(1, s2);
        enable = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            compared++; if (writeEn !== (c == 4)) begin mismatched++; $display("[TB] FAIL restart_we c=%0d: got %b expected %b", c, writeEn, (c == 4)); end
            if (c == 4) begin
                compared++; if (pdmInput !== s2[0]) begin mismatched++; $display("[TB] FAIL restart_data: got %h expected %h", pdmInput, s2[0]); end
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] s [4];
        doReset(1);
        preload(4, s);
        enable = 1'b1;
        step(); step(); step();
        compared++; if (writeEn !== 1'b1)   begin mismatched++; $display("[TB] FAIL midrst_pre_we: got %b expected 1", writeEn); end
        compared++; if (fifoLevel !== 3'd3) begin mismatched++; $display("[TB] FAIL midrst_pre_level: got %0d expected 3", fifoLevel); end
        reset = 1'b1;
        #1;
        compared++; if (writeEn !== 1'b0)   begin mismatched++; $display("[TB] FAIL midrst_we: got %b expected 0", writeEn); end
        compared++; if (pdmInput !== 8'h00) begin mismatched++; $display("[TB] FAIL midrst_pdm: got %h expected 00", pdmInput); end
        compared++; if (fifoLevel !== 3'd0) begin mismatched++; $display("[TB] FAIL midrst_level: got %0d expected 0", fifoLevel); end
        compared++; if (busy !== 1'b0)      begin mismatched++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
        compared++; if (underflow !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_underflow: got %b expected 0", underflow); end
        enable = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_drain_resume();
        logic [7:0] s [4];
        logic [7:0] later;
        bit expWe;
        later = 8'($urandom_range(1, 255));
        doReset(2);
        preload(1, s);
        enable = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            expWe = (c == 4 || c == 10);
            compared++; if (writeEn !== expWe) begin mismatched++; $display("[TB] FAIL resume_we c=%0d: got %b expected %b", c, writeEn, expWe); end
            if (expWe) begin
                compared++; if (pdmInput !== ((c == 4) ? s[0] : later)) begin mismatched++; $display("[TB] FAIL resume_data c=%0d: got %h expected %h", c, pdmInput, ((c == 4) ? s[0] : later)); end
            end
            compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL resume_busy c=%0d: got %b expected 1", c, busy); end
            compared++; if (underflow !== (c >= 7)) begin mismatched++; $display("[TB] FAIL resume_underflow c=%0d: got %b expected %b", c, underflow, (c >= 7)); end
            if (c == 1) enable = 1'b0;
            if (c == 5) enable = 1'b1;
            if (c == 8) begin sValid = 1'b1; sData = later; end
            if (c == 9) sValid = 1'b0;
        end
        enable = 1'b0;
    endtask

    task automatic test_random(input int p, input int cycles, input bit toggleEn);
        bit v;
        bit en;
        logic [7:0] d;
        doReset(p);
        modelReset(p);
        en = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            v = ($urandom_range(0, 99) < 60);
            d = 8'($urandom);
            if (toggleEn && $urandom_range(0, 99) < 8) en = !en;
            sValid = v;
            sData  = d;
            enable = en;
            modelStep(v, d, en);
            step();
            compared++; if (writeEn !== mWe) begin mismatched++; $display("[TB] FAIL rand_we p=%0d i=%0d: got %b expected %b", p, i, writeEn, mWe); end
            compared++; if (pdmInput !== mOut) begin mismatched++; $display("[TB] FAIL rand_data p=%0d i=%0d: got %h expected %h", p, i, pdmInput, mOut); end
            compared++; if (fifoLevel !== 3'(mq.size())) begin mismatched++; $display("[TB] FAIL rand_level p=%0d i=%0d: got %0d expected %0d", p, i, fifoLevel, mq.size()); end
            compared++; if (sReady !== (mq.size() < DEPTH)) begin mismatched++; $display("[TB] FAIL rand_ready p=%0d i=%0d: got %b expected %b", p, i, sReady, (mq.size() < DEPTH)); end
            compared++; if (busy !== (mMode != 0)) begin mismatched++; $display("[TB] FAIL rand_busy p=%0d i=%0d: got %b expected %b", p, i, busy, (mMode != 0)); end
            compared++; if (underflow !== mUf) begin mismatched++; $display("[TB] FAIL rand_underflow p=%0d i=%0d: got %b expected %b", p, i, underflow, mUf); end
        end
        sValid = 1'b0;
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_preload();
        test_full_pop();
        test_drain();
        test_reset_mid();
        test_drain_resume();
        test_random(0, 40, 1'b0);
        test_random(2, 80, 1'b0);
        test_random(int'($urandom_range(0, 3)), 200, 1'b1);
        test_random(1, 200, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
